extmem_seq: RTL and testbench
=============================

# extmem_seq

Parametrised external SRAM sequencer for the frame-buffer path: alternates a full write pass and a full read pass over a configurable address window, generating `ce_n`/`wr_n`/`oe_n` with programmable strobe width. It replaces the fixed 64K-word, fixed-timing controller with separate write and read pointers and a clean idle state. It adds per-word handshake pulses and a pass-complete pulse for the pixel pipeline.

## Interface
- `ADDR_W`, 16, address bus width.
- `MAX_ADDR`, 2**ADDR_W-1, last address of the pass window; legal range 1..2**ADDR_W-1.
- `WAIT_CYC`, 1, strobe-low cycles per word; legal range 1..15.

- `clk_out`  in  1  sole clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `hold`  in  1  freeze: all registers and outputs keep their value.
- `endram`  in  1  run enable, level-sensitive.
- `addr`  out  ADDR_W  SRAM address: write pointer when `rwn`=0, read pointer when `rwn`=1.
- `rwn`  out  1  pass direction: 0 = write pass, 1 = read pass.
- `ce_n`  out  1  chip enable, active-low.
- `wr_n`  out  1  write strobe, active-low.
- `oe_n`  out  1  output enable, active-low.
- `wr_ack`  out  1  one-cycle pulse: write word complete; upstream presents next data.
- `rd_valid`  out  1  one-cycle pulse: read data valid on the SRAM bus this cycle.
- `pass_done`  out  1  one-cycle pulse at the end of each pass.
- `busy`  out  1  high in any state other than IDLE/DONE.

## Operation
- FSM states: IDLE, SETUP, STROBE, RECOV, plus DONE (only with the macro).
- IDLE: `ce_n`=1, strobes high. If `endram`=1, go to SETUP.
- SETUP, 1 cycle: `ce_n`=0; `addr` stable; strobes high.
- STROBE, WAIT_CYC cycles (4-bit down-counter): `wr_n`=0 if `rwn`=0, else `oe_n`=0.
  - On the last STROBE cycle of a read, `rd_valid`=1.
- RECOV, 1 cycle: strobes high, `ce_n`=0.
  - If `rwn`=0, pulse `wr_ack`.
  - Advance the active pointer, wrapping MAX_ADDR to 0.
  - If the pointer was at MAX_ADDR, toggle `rwn` and pulse `pass_done`.
  - Next state is SETUP if `endram`=1, else IDLE.
- Pointer behaviour:
  - The write and read pointers are independent; the inactive pointer holds.
  - A pass stopped by `endram`=0 resumes at the next word.
- `endram` falling mid-word: the word always completes through RECOV; no truncated strobes.
- `hold`=1: the FSM, wait counter, pointers, `rwn` and all outputs freeze.
  - Pulse outputs keep their current value, so a pulse stretches across the hold.
  - `hold` has priority over `endram`.
  - `reset_n` has priority over everything.
- Pointer arithmetic is ADDR_W bits wide. The wrap compare is `== MAX_ADDR`, never an overflow carry.

## Timing
- Reset values:
  - `addr`=0, `rwn`=0
  - `ce_n`=1, `wr_n`=1, `oe_n`=1
  - `wr_ack`=0, `rd_valid`=0, `pass_done`=0, `busy`=0
  - state IDLE, both pointers 0.
- All outputs are registered. Changes appear one clock after the qualifying edge.
- Word period is WAIT_CYC+2 cycles. A pass is (MAX_ADDR+1)×(WAIT_CYC+2) cycles.
- Per-word sequencing:
  - `addr` changes only on the RECOV→SETUP/IDLE edge; it is stable for the whole SETUP..RECOV.
  - Strobe low never overlaps an address change.
- First `ce_n` fall: 1 cycle after `endram` is sampled high in IDLE.
- `pass_done` coincides with the RECOV of word MAX_ADDR. The next SETUP uses the new `rwn`, with pointer 0.
- Reset asserted mid-operation: outputs take their reset values immediately (asynchronous), including strobes.

## Configuration
- Macro: `EXTMEM_SEQ_SINGLE_SHOT_EN`.
- Defined:
  - After the read pass completes, the FSM enters DONE: `ce_n`=1, `busy`=0, `rwn`=0, pointers 0.
  - It stays in DONE while `endram`=1 and returns to IDLE when `endram`=0.
  - Exactly one write pass plus one read pass occurs per `endram` assertion.
- Undefined:
  - There is no DONE state; passes alternate write/read indefinitely while `endram`=1.

## Test plan
All scenarios use MAX_ADDR=3, WAIT_CYC=2, i.e. 4 cycles per word.
- Reset release with `endram`=0 → all outputs at reset values; `ce_n` stays 1 for 20 cycles.
- `endram`=1 held → `wr_n` low 2 cycles per word at addr 0,1,2,3; 4 `wr_ack` pulses; `pass_done` at cycle 16, `rwn`→1; then `oe_n` low at addr 0..3 with 4 `rd_valid` pulses.
- Drop `endram` during STROBE of write word 1 → word 1 completes, `wr_ack` pulses, IDLE with `ce_n`=1; re-assert → resumes at addr 2.
- `hold`=1 for 5 cycles during STROBE → `wr_n` stays 0 and `addr` is constant for the extra 5 cycles; the strobe totals 7 low cycles; the sequence then continues unchanged.
- Assert `reset_n`=0 mid-read-pass at addr 2 → `oe_n`=1, `ce_n`=1, `rwn`=0, `addr`=0 with no clock edge.
- With `EXTMEM_SEQ_SINGLE_SHOT_EN`: `endram`=1 held → 2 `pass_done` pulses, then `busy`=0 and `ce_n`=1 for 50 cycles; toggle `endram` low→high → a new write pass starts at addr 0.

Source files
------------

// File: rtl/extmem_seq_if.sv
// extmem_seq_if
//   Bundles the sequencer's run controls and SRAM/pixel-pipeline outputs.
//   master : the sequencer (drives SRAM controls and handshake pulses)
//   slave  : the system side (drives hold/endram, observes the rest)
//   Signals:
//     hold, endram          run controls into the sequencer
//     addr[ADDR_W-1:0]      SRAM address
//     rwn                   pass direction (0 write, 1 read)
//     ce_n, wr_n, oe_n      SRAM strobes, active-low
//     wr_ack, rd_valid      per-word handshake pulses
//     pass_done, busy       pass-complete pulse and activity flag
interface extmem_seq_if #(
   parameter int ADDR_W = 16
);
   logic              hold;
   logic              endram;
   logic [ADDR_W-1:0] addr;
   logic              rwn;
   logic              ce_n;
   logic              wr_n;
   logic              oe_n;
   logic              wr_ack;
   logic              rd_valid;
   logic              pass_done;
   logic              busy;

   modport master (
      input  hold, endram,
      output addr, rwn, ce_n, wr_n, oe_n, wr_ack, rd_valid, pass_done, busy
   );

   modport slave (
      output hold, endram,
      input  addr, rwn, ce_n, wr_n, oe_n, wr_ack, rd_valid, pass_done, busy
   );
endinterface

// File: rtl/extmem_seq.sv
// extmem_seq
//   External SRAM sequencer for the frame-buffer path. Alternates a full
//   write pass and a full read pass over addresses 0..MAX_ADDR, with
//   independent write/read pointers and a strobe held low WAIT_CYC cycles
//   per word. Every output is registered and lines up with the FSM state.
//   Ports:
//     clk_out  sole clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      extmem_seq_if.master (hold/endram in, SRAM controls and
//              handshake pulses out)
//   Build option:
//     EXTMEM_SEQ_SINGLE_SHOT_EN  one write pass plus one read pass per
//                                endram assertion, then park in DONE.
//
//   state  | meaning
//   IDLE   | chip deselected, waiting for endram
//   SETUP  | ce_n low, address settling, strobes high
//   STROBE | wr_n or oe_n low for WAIT_CYC cycles
//   RECOV  | strobes high, pointer advance, wr_ack/pass_done pulses
//   DONE   | single-shot build only: both passes finished, wait endram=0
module extmem_seq #(
   parameter int ADDR_W   = 16,
   parameter int MAX_ADDR = 2**ADDR_W-1,
   parameter int WAIT_CYC = 1
) (
   input logic           clk_out,
   input logic           reset_n,
   extmem_seq_if.master  bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_RECOV  = 3'd3
`ifdef EXTMEM_SEQ_SINGLE_SHOT_EN
      , S_DONE = 3'd4
`endif
   } state_t;

   localparam logic [ADDR_W-1:0] MAX_A    = ADDR_W'(MAX_ADDR);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
   localparam logic [3:0]        CNT_LOAD = 4'(WAIT_CYC - 1);

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [ADDR_W-1:0] wr_ptr, wr_ptr_nxt;
   logic [ADDR_W-1:0] rd_ptr, rd_ptr_nxt;
   logic              rwn_q, rwn_nxt;
   logic              last_word;

   logic [ADDR_W-1:0] addr_q, addr_nxt;
   logic              ce_n_q, ce_n_nxt;
   logic              wr_n_q, wr_n_nxt;
   logic              oe_n_q, oe_n_nxt;
   logic              wr_ack_q, wr_ack_nxt;
   logic              rd_valid_q, rd_valid_nxt;
   logic              pass_done_q, pass_done_nxt;
   logic              busy_q, busy_nxt;

   // State, counter, pointers and output registers. hold freezes all of
   // them, so a pulse that is high when hold rises stays high.
   always_ff @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         cnt         <= 4'd0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rwn_q       <= 1'b0;
         addr_q      <= '0;
         ce_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         oe_n_q      <= 1'b1;
         wr_ack_q    <= 1'b0;
         rd_valid_q  <= 1'b0;
         pass_done_q <= 1'b0;
         busy_q      <= 1'b0;
      end else if (!bus.hold) begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         wr_ptr      <= wr_ptr_nxt;
         rd_ptr      <= rd_ptr_nxt;
         rwn_q       <= rwn_nxt;
         addr_q      <= addr_nxt;
         ce_n_q      <= ce_n_nxt;
         wr_n_q      <= wr_n_nxt;
         oe_n_q      <= oe_n_nxt;
         wr_ack_q    <= wr_ack_nxt;
         rd_valid_q  <= rd_valid_nxt;
         pass_done_q <= pass_done_nxt;
         busy_q      <= busy_nxt;
      end
   end

   // Next state, wait counter and pointer update.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      wr_ptr_nxt = wr_ptr;
      rd_ptr_nxt = rd_ptr;
      rwn_nxt    = rwn_q;
      last_word  = ((rwn_q ? rd_ptr : wr_ptr) == MAX_A);

      case (state)
         S_IDLE: begin
            if (bus.endram) state_nxt = S_SETUP;
         end
         S_SETUP: begin
            state_nxt = S_STROBE;
            cnt_nxt   = CNT_LOAD;
         end
         S_STROBE: begin
            if (cnt == 4'd0) state_nxt = S_RECOV;
            else             cnt_nxt   = cnt - 4'd1;
         end
         S_RECOV: begin
            // Wrap is an explicit compare so a window smaller than the
            // address space wraps at MAX_ADDR, not at the carry.
            if (rwn_q) rd_ptr_nxt = last_word ? '0 : rd_ptr + PTR_ONE;
            else       wr_ptr_nxt = last_word ? '0 : wr_ptr + PTR_ONE;
            if (last_word) rwn_nxt = ~rwn_q;
            state_nxt = bus.endram ? S_SETUP : S_IDLE;
`ifdef EXTMEM_SEQ_SINGLE_SHOT_EN
            if (last_word && rwn_q) begin
               state_nxt  = S_DONE;
               rwn_nxt    = 1'b0;
               wr_ptr_nxt = '0;
               rd_ptr_nxt = '0;
            end
`endif
         end
`ifdef EXTMEM_SEQ_SINGLE_SHOT_EN
         S_DONE: begin
            if (!bus.endram) state_nxt = S_IDLE;
         end
`endif
         default: state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies
   // change on the same edge as the state they describe.
   always_comb begin
      busy_nxt      = (state_nxt == S_SETUP) || (state_nxt == S_STROBE) ||
                      (state_nxt == S_RECOV);
      ce_n_nxt      = ~busy_nxt;
      wr_n_nxt      = ~((state_nxt == S_STROBE) && !rwn_nxt);
      oe_n_nxt      = ~((state_nxt == S_STROBE) && rwn_nxt);
      rd_valid_nxt  = (state_nxt == S_STROBE) && rwn_nxt && (cnt_nxt == 4'd0);
      wr_ack_nxt    = (state_nxt == S_RECOV) && !rwn_nxt;
      addr_nxt      = rwn_nxt ? rd_ptr_nxt : wr_ptr_nxt;
      pass_done_nxt = (state_nxt == S_RECOV) && (addr_nxt == MAX_A);
   end

   assign bus.addr      = addr_q;
   assign bus.rwn       = rwn_q;
   assign bus.ce_n      = ce_n_q;
   assign bus.wr_n      = wr_n_q;
   assign bus.oe_n      = oe_n_q;
   assign bus.wr_ack    = wr_ack_q;
   assign bus.rd_valid  = rd_valid_q;
   assign bus.pass_done = pass_done_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_extmem_seq.sv
// tb_extmem_seq
//   Bench for extmem_seq with ADDR_W=4, MAX_ADDR=3, WAIT_CYC=2. A word-level
//   model (idle/done flags, phase within the word, two pointers) predicts
//   every output each cycle; directed scenarios add literal expectations.
module tb_extmem_seq;
   localparam int AW   = 4;
   localparam int MAXA = 3;
   localparam int W    = 2;

   logic clk_out = 1'b0;
   logic reset_n = 1'b1;
   int   n_vec   = 0;
   int   n_err   = 0;

   extmem_seq_if #(.ADDR_W(AW)) bus ();

   extmem_seq #(.ADDR_W(AW), .MAX_ADDR(MAXA), .WAIT_CYC(W)) dut (
      .clk_out (clk_out),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk_out = ~clk_out;

   // ---------------- behavioural model ----------------
   // phase: 0 = address setup, 1..W = strobe low, W+1 = recovery
   bit m_idle = 1'b1, m_done = 1'b0, m_rwn = 1'b0;
   int m_phase = 0, m_wp = 0, m_rp = 0, m_cur = 0, m_nxt = 0;

   always @(posedge clk_out or negedge reset_n) begin
      if (!reset_n) begin
         m_idle = 1'b1; m_done = 1'b0; m_rwn = 1'b0;
         m_phase = 0; m_wp = 0; m_rp = 0;
      end else if (!bus.hold) begin
         if (m_done) begin
            if (!bus.endram) begin m_done = 1'b0; m_idle = 1'b1; end
         end else if (m_idle) begin
            if (bus.endram) begin m_idle = 1'b0; m_phase = 0; end
         end else if (m_phase < W + 1) begin
            m_phase = m_phase + 1;
         end else begin
            m_cur = m_rwn ? m_rp : m_wp;
            m_nxt = (m_cur == MAXA) ? 0 : m_cur + 1;
            if (m_rwn) m_rp = m_nxt; else m_wp = m_nxt;
            m_phase = 0;
            m_idle  = !bus.endram;
            if (m_cur == MAXA) begin
`ifdef EXTMEM_SEQ_SINGLE_SHOT_EN
               if (m_rwn) begin
                  m_done = 1'b1; m_idle = 1'b0;
                  m_rwn = 1'b0; m_wp = 0; m_rp = 0;
               end else begin
                  m_rwn = 1'b1;
               end
`else
               m_rwn = !m_rwn;
`endif
            end
         end
      end
   end

   function automatic logic [11:0] exp_vec();
      bit act, strb;
      int a;
      act  = !m_idle && !m_done;
      strb = act && (m_phase >= 1) && (m_phase <= W);
      a    = m_rwn ? m_rp : m_wp;
      return {AW'(a), m_rwn, !act, !(strb && !m_rwn), !(strb && m_rwn),
              act && (m_phase == W + 1) && !m_rwn,
              act && (m_phase == W) && m_rwn,
              act && (m_phase == W + 1) && (a == MAXA),
              act};
   endfunction

   function automatic logic [11:0] act_vec();
      return {bus.addr, bus.rwn, bus.ce_n, bus.wr_n, bus.oe_n,
              bus.wr_ack, bus.rd_valid, bus.pass_done, bus.busy};
   endfunction

   // Per-cycle compare against the model, away from the rising edge.
   always @(negedge clk_out) begin
      n_vec++;
      if (act_vec() !== exp_vec()) begin
         n_err++;
         $display("FAIL model_cmp t=%0t {addr,rwn,ce_n,wr_n,oe_n,wr_ack,rd_valid,pass_done,busy} dut=%b model=%b",
                  $time, act_vec(), exp_vec());
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Leaves the bench at negedge+2 with reset released, endram=0, hold=0.
   task automatic do_reset();
      @(negedge clk_out); #2;
      reset_n = 1'b0; bus.endram = 1'b0; bus.hold = 1'b0;
      @(negedge clk_out); #2;
      reset_n = 1'b1;
   endtask

   int n_a, n_b, n_c, n_d, n_e, n_f;

   initial begin
      bus.endram = 1'b0;
      bus.hold   = 1'b0;
      #1 reset_n = 1'b0;
      @(negedge clk_out); #2;
      reset_n = 1'b1;

      // Idle after reset: chip stays deselected for 20 cycles.
      n_a = 0; n_b = 0; n_c = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk_out);
         if (bus.ce_n == 1'b1) n_a++;
         if (bus.busy == 1'b0) n_b++;
         if (bus.addr == '0 && bus.rwn == 1'b0 && bus.wr_n && bus.oe_n) n_c++;
      end
      chk("idle_ce_n_high", n_a, 20);
      chk("idle_busy_low", n_b, 20);
      chk("idle_addr_strobes", n_c, 20);

      // Continuous run: one write pass then one read pass.
      do_reset();
      bus.endram = 1'b1;
      n_a = 0; n_b = 0; n_c = 0; n_d = 0; n_e = 0;
      for (int c = 1; c <= 32; c++) begin
         @(negedge clk_out);
         if (bus.wr_ack)    n_a++;
         if (bus.rd_valid)  n_b++;
         if (!bus.wr_n)     n_c++;
         if (!bus.oe_n)     n_d++;
         if (bus.pass_done) n_e++;
         if (c == 1)  chk("first_ce_n_fall", bus.ce_n, 0);
         if (c == 2)  chk("word0_wr_n", bus.wr_n, 0);
         if (c == 5)  chk("word1_addr", bus.addr, 1);
         if (c == 16) chk("pass_done_c16", bus.pass_done, 1);
         if (c == 16) chk("last_write_addr", bus.addr, 3);
         if (c == 17) chk("read_rwn", bus.rwn, 1);
         if (c == 17) chk("read_start_addr", bus.addr, 0);
         if (c == 19) chk("first_rd_valid", bus.rd_valid, 1);
      end
      chk("wr_ack_count", n_a, 4);
      chk("rd_valid_count", n_b, 4);
      chk("wr_n_low_cycles", n_c, 8);
      chk("oe_n_low_cycles", n_d, 8);
      chk("pass_done_count", n_e, 2);
`ifdef EXTMEM_SEQ_SINGLE_SHOT_EN
      n_f = 0;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk_out);
         if (!bus.busy && bus.ce_n && !bus.rwn && bus.addr == '0) n_f++;
      end
      chk("done_parked_50", n_f, 50);
      #2 bus.endram = 1'b0;
      @(negedge clk_out); @(negedge clk_out); #2;
      bus.endram = 1'b1;
      @(negedge clk_out);
      chk("restart_ce_n", bus.ce_n, 0);
      chk("restart_addr", bus.addr, 0);
      chk("restart_rwn", bus.rwn, 0);
`else
      @(negedge clk_out);
      chk("second_write_ce_n", bus.ce_n, 0);
      chk("second_write_rwn", bus.rwn, 0);
      chk("second_write_addr", bus.addr, 0);
`endif

      // endram dropped in the strobe of write word 1.
      do_reset();
      bus.endram = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk_out);
         if (c == 8)  chk("stop_wr_ack", bus.wr_ack, 1);
         if (c == 8)  chk("stop_recov_addr", bus.addr, 1);
         if (c == 9)  chk("stop_idle_ce_n", bus.ce_n, 1);
         if (c == 9)  chk("stop_idle_addr", bus.addr, 2);
         if (c == 11) chk("resume_ce_n", bus.ce_n, 0);
         if (c == 11) chk("resume_addr", bus.addr, 2);
         if (c == 12) chk("resume_wr_n", bus.wr_n, 0);
         if (c == 6)  begin #2 bus.endram = 1'b0; end
         if (c == 10) begin #2 bus.endram = 1'b1; end
      end

      // hold for 5 cycles during the first write strobe.
      do_reset();
      bus.endram = 1'b1;
      n_a = 0; n_b = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk_out);
         if (c <= 9 && !bus.wr_n)     n_a++;
         if (c <= 9 && bus.addr == 0) n_b++;
         if (c == 9)  chk("hold_wr_ack", bus.wr_ack, 1);
         if (c == 10) chk("hold_next_addr", bus.addr, 1);
         if (c == 2)  begin #2 bus.hold = 1'b1; end
         if (c == 7)  begin #2 bus.hold = 1'b0; end
      end
      chk("hold_strobe_len", n_a, 7);
      chk("hold_addr_stable", n_b, 9);

      // Asynchronous reset in the strobe of read word 2.
      do_reset();
      bus.endram = 1'b1;
      for (int c = 1; c <= 26; c++) @(negedge clk_out);
      chk("pre_rst_oe_n", bus.oe_n, 0);
      chk("pre_rst_addr", bus.addr, 2);
      chk("pre_rst_rwn", bus.rwn, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_oe_n", bus.oe_n, 1);
      chk("rst_ce_n", bus.ce_n, 1);
      chk("rst_rwn", bus.rwn, 0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_busy", bus.busy, 0);
      @(negedge clk_out); #2;
      reset_n = 1'b1;

      // Randomized run checked cycle by cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk_out); #2;
         if ($urandom_range(0, 9) < 2) bus.endram = ~bus.endram;
         bus.hold = ($urandom_range(0, 9) == 0);
         reset_n  = ($urandom_range(0, 299) != 0);
      end
      @(negedge clk_out); #2;
      reset_n = 1'b1;
      @(negedge clk_out);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
